// File: rtl/divergence_roll_ctrl.sv
// Divergence meter roll sequencer: scrambles eight BCD digits,
// then locks them to a latched target one at a time, MSD first.
module divergence_roll_ctrl #(
  parameter int SCRAMBLE_DIV = 2_500_000,
  parameter int LOCK_STEPS   = 20,
  parameter int LOCK_GAP     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] rnd,
  output logic [31:0] disp_data,
  output logic [7:0]  locked,
  output logic        busy,
  output logic        done
);

  localparam int T  = LOCK_STEPS + 7 * LOCK_GAP;
  localparam int TW = $clog2(T + 1);
  localparam int CW = $clog2(SCRAMBLE_DIV);

  typedef enum logic [1:0] {
    IDLE,
    SCRAMBLE,
    LOCKING
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] idx, idx_d, nidx;
  logic [31:0]   tgt, tgt_d;
  logic [31:0]   disp_d, rnd_dig;
  logic [7:0]    locked_d;
  logic          busy_d, done_d;
  logic          tick;

  function automatic logic [3:0] red(input logic [3:0] n);
    return (n >= 4'd10) ? n - 4'd10 : n;
  endfunction

  // MSD only ever shows 0 or 1
  function automatic logic [31:0] digits(input logic [31:0] w);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 7; k++) begin
      d[4*k +: 4] = red(w[4*k +: 4]);
    end
    d[31:28] = {3'b0, w[28]};
    return d;
  endfunction

  assign rnd_dig = digits(rnd);
  assign tick    = (cnt == CW'(SCRAMBLE_DIV - 1));
  assign nidx    = idx + TW'(1);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    tgt_d    = tgt;
    disp_d   = disp_data;
    locked_d = locked;
    busy_d   = busy;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          tgt_d    = rnd_dig;
          locked_d = '0;
          cnt_d    = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = SCRAMBLE;
        end
      end
      SCRAMBLE, LOCKING: begin
        if (!tick) begin
          cnt_d = cnt + CW'(1);
        end else begin
          cnt_d = '0;
          idx_d = nidx;
          for (int k = 0; k < 8; k++) begin
            if (!locked[k]) begin
              if (int'(nidx) == LOCK_STEPS + (7 - k) * LOCK_GAP) begin
                disp_d[4*k +: 4] = tgt[4*k +: 4];
                locked_d[k]      = 1'b1;
              end else begin
                disp_d[4*k +: 4] = rnd_dig[4*k +: 4];
              end
            end
          end
          if (locked_d[7]) state_d = LOCKING;
          if (locked_d[0]) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      tgt       <= '0;
      disp_data <= '0;
      locked    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      tgt       <= tgt_d;
      disp_data <= disp_d;
      locked    <= locked_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_divergence_roll_ctrl.sv
// Directed bench for divergence_roll_ctrl with a short
// tick period so full rolls fit in a few dozen cycles.
module tb_divergence_roll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] rnd;
  logic [31:0] disp_data;
  logic [7:0]  locked;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  int busy_cnt, done_cnt, done_at, bad_nib, bad_hold;
  int lk_at[8];
  int idle_done;
  logic [31:0] prev_disp;
  logic [7:0]  prev_lk;

  divergence_roll_ctrl #(
    .SCRAMBLE_DIV(4),
    .LOCK_STEPS(3),
    .LOCK_GAP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rnd(rnd),
    .disp_data(disp_data),
    .locked(locked),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int c, input logic skip_hold);
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = c;
    end
    for (int k = 0; k < 8; k++) begin
      if (locked[k] && lk_at[k] < 0) lk_at[k] = c;
      if (disp_data[4*k +: 4] > 4'd9) bad_nib++;
      if (prev_lk[k] && locked[k] &&
          disp_data[4*k +: 4] != prev_disp[4*k +: 4]) bad_hold++;
    end
    if ((c % 4) != 0 && disp_data != prev_disp && !skip_hold)
      bad_hold++;
    prev_disp = disp_data;
    prev_lk   = locked;
  endtask

  // mode 0 plain, 1 start pulses mid-roll, 2 reset at E0+30
  task automatic roll(input logic [31:0] tgt, input int mode,
                      input int ncyc);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    bad_nib  = 0;
    bad_hold = 0;
    for (int k = 0; k < 8; k++) lk_at[k] = -1;
    rnd   = tgt;
    start = 1'b1;
    step();
    start = 1'b0;
    if (busy) busy_cnt++;
    prev_disp = disp_data;
    prev_lk   = locked;
    for (int c = 1; c <= ncyc; c++) begin
      rnd   = $urandom;
      start = (mode == 1) && (c == 5 || c == 40);
      rst   = (mode == 2) && (c == 30);
      step();
      start = 1'b0;
      rst   = 1'b0;
      watch(c, (mode == 2) && (c == 30));
      if (mode == 2 && c == 30) begin
        chk("rst_disp", disp_data, 32'h0);
        chk("rst_lock", {24'h0, locked}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
      end
    end
  endtask

  task automatic check_roll(input string tag, input logic [31:0] exp);
    chk({tag, "_busy_len"}, busy_cnt, 68);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_at, 68);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_lock%0d", tag, k), lk_at[k], 12 + 8 * (7 - k));
    chk({tag, "_disp"}, disp_data, exp);
    chk({tag, "_locked"}, {24'h0, locked}, 32'hFF);
    chk({tag, "_nibble"}, bad_nib, 0);
    chk({tag, "_hold"}, bad_hold, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rnd   = 32'h0;
    step();
    start = 1'b1;
    rnd   = 32'h1A3F5C07;
    step();
    start = 1'b0;
    chk("reset_disp", disp_data, 32'h0);
    chk("reset_lock", {24'h0, locked}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    rst = 1'b0;

    idle_done = 0;
    for (int i = 0; i < 100; i++) begin
      rnd = $urandom;
      step();
      if (done || busy) idle_done++;
    end
    chk("idle_disp", disp_data, 32'h0);
    chk("idle_lock", {24'h0, locked}, 32'h0);
    chk("idle_activity", idle_done, 0);

    roll(32'h1A3F5C07, 0, 80);
    check_roll("plain", 32'h10355207);

    roll(32'h1A3F5C07, 1, 80);
    check_roll("disturb", 32'h10355207);

    roll(32'h1A3F5C07, 2, 40);
    chk("rst_hold_busy", {31'h0, busy}, 32'h0);
    chk("rst_hold_disp", disp_data, 32'h0);
    roll(32'h1A3F5C07, 0, 80);
    check_roll("after_rst", 32'h10355207);

    rnd   = 32'h1A3F5C07;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 68; c++) begin
      rnd = $urandom;
      step();
    end
    start = 1'b1;
    rnd   = 32'h00000000;
    step();
    chk("done_edge_done", {31'h0, done}, 32'h1);
    chk("done_edge_busy", {31'h0, busy}, 32'h0);
    chk("done_edge_disp", disp_data, 32'h10355207);
    rnd = 32'h98765432;
    step();
    start = 1'b0;
    chk("restart_busy", {31'h0, busy}, 32'h1);
    chk("restart_lock", {24'h0, locked}, 32'h0);
    chk("restart_disp", disp_data, 32'h10355207);
    chk("restart_done", {31'h0, done}, 32'h0);
    for (int c = 1; c <= 70; c++) begin
      rnd = $urandom;
      step();
    end
    chk("restart_final", disp_data, 32'h18765432);
    chk("restart_locked", {24'h0, locked}, 32'hFF);
    chk("restart_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
